imm_packer: RTL and testbench

- Inverse of the datapath immediate extractor: takes a 64-bit immediate value plus an instruction-format code and packs it into the 26-bit instruction immediate field layout.
- Reports whether the value is representable in that format.
- Sits in the program-loader/assembler path ahead of instruction memory.
- Uses a valid/ready handshake on both sides; the IW format needs a multi-cycle halfword scan.

---
 rtl/imm_packer.sv | 139 +++++++++++++
 tb/tb_imm_packer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_packer.sv
// Packs a 64-bit immediate into the 26-bit instruction immediate field for the given format
// and reports whether the value is representable; IW formats scan halfwords over four cycles.
module imm_packer (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic        InValid,
    output logic        InReady,
    input  logic [63:0] BusImm,
    input  logic [2:0]  Ctrl,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [25:0] Imm25,
    output logic        Fit
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SCAN,
        HOLD
    } state_t;

    state_t      state;
    logic [63:0] val;
    logic [2:0]  ctrl;
    logic [1:0]  hw;
    logic [2:0]  nz_cnt;
    logic [1:0]  nz_idx;
    logic [15:0] nz_val;

    logic [25:0] calc_imm;
    logic        calc_fit;
    logic [15:0] cur_hw;
    logic        hw_nz;
    logic [2:0]  cnt_nxt;
    logic [1:0]  idx_nxt;
    logic [15:0] val_nxt;
    logic        iw_fit;
    logic [25:0] iw_imm;

    assign InReady = (state == IDLE) && Reset_L;

    // Sign-extended formats fit when every bit above the field matches the field's top bit.
    always_comb begin
        calc_imm = '0;
        calc_fit = 1'b0;
        case (ctrl)
            3'b000: begin
                calc_imm = {4'b0, val[11:0], 10'b0};
                calc_fit = (val[63:12] == '0);
            end
            3'b001: begin
                calc_imm = {5'b0, val[8:0], 12'b0};
                calc_fit = (&val[63:8]) || !(|val[63:8]);
            end
            3'b010: begin
                calc_imm = val[25:0];
                calc_fit = (&val[63:25]) || !(|val[63:25]);
            end
            3'b011: begin
                calc_imm = {2'b0, val[18:0], 5'b0};
                calc_fit = (&val[63:18]) || !(|val[63:18]);
            end
            3'b100: begin
                calc_imm = {10'b0, val[5:0], 10'b0};
                calc_fit = (val[63:6] == '0);
            end
            default: begin
                calc_imm = '0;
                calc_fit = 1'b0;
            end
        endcase
    end

    always_comb begin
        cur_hw  = val[{hw, 4'b0} +: 16];
        hw_nz   = |cur_hw;
        cnt_nxt = nz_cnt + {2'b0, hw_nz};
        idx_nxt = hw_nz ? hw : nz_idx;
        val_nxt = hw_nz ? cur_hw : nz_val;
        iw_fit  = (cnt_nxt <= 3'd1);
        iw_imm  = iw_fit ? {3'b0, idx_nxt, val_nxt, 5'b0} : '0;
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state    <= IDLE;
            val      <= '0;
            ctrl     <= '0;
            hw       <= '0;
            nz_cnt   <= '0;
            nz_idx   <= '0;
            nz_val   <= '0;
            OutValid <= 1'b0;
            Imm25    <= '0;
            Fit      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        val    <= BusImm;
                        ctrl   <= Ctrl;
                        hw     <= '0;
                        nz_cnt <= '0;
                        nz_idx <= '0;
                        nz_val <= '0;
                        state  <= (Ctrl == 3'b101) ? SCAN : CALC;
                    end
                end
                CALC: begin
                    Imm25    <= calc_imm;
                    Fit      <= calc_fit;
                    OutValid <= 1'b1;
                    state    <= HOLD;
                end
                SCAN: begin
                    nz_cnt <= cnt_nxt;
                    nz_idx <= idx_nxt;
                    nz_val <= val_nxt;
                    hw     <= hw + 2'd1;
                    if (hw == 2'd3) begin
                        Imm25    <= iw_imm;
                        Fit      <= iw_fit;
                        OutValid <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_packer.sv
// Self-checking bench for imm_packer: directed cases plus randomized requests compared
// against an arithmetic reference model and a round-trip through an extractor model.
module tb_imm_packer;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic        InValid = 1'b0;
    logic        OutReady = 1'b0;
    logic [63:0] BusImm = '0;
    logic [2:0]  Ctrl = '0;
    logic        InReady;
    logic        OutValid;
    logic [25:0] Imm25;
    logic        Fit;

    int checks = 0;
    int errors = 0;

    imm_packer dut (
        .CLK      (CLK),
        .Reset_L  (Reset_L),
        .InValid  (InValid),
        .InReady  (InReady),
        .BusImm   (BusImm),
        .Ctrl     (Ctrl),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Imm25    (Imm25),
        .Fit      (Fit)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic signed_fits(input logic [63:0] v, input int n);
        longint s;
        longint lim;
        s   = v;
        lim = longint'(1) << (n - 1);
        return (s >= -lim) && (s < lim);
    endfunction

    function automatic logic [63:0] sext(input logic [63:0] x, input int n);
        logic [63:0] m;
        m = 64'd1 << n;
        x = x & (m - 64'd1);
        if (x[n-1]) return x - m;
        return x;
    endfunction

    function automatic void model(input logic [63:0] v, input logic [2:0] c,
                                  output logic [25:0] imm, output logic fit);
        int          cnt;
        int          idx;
        logic [63:0] hv;
        logic [63:0] h;
        imm = '0;
        fit = 1'b0;
        case (c)
            3'd0: begin imm = 26'((v & 64'hFFF) << 10);    fit = (v < 64'd4096); end
            3'd1: begin imm = 26'((v & 64'h1FF) << 12);    fit = signed_fits(v, 9);  end
            3'd2: begin imm = 26'(v & 64'h3FF_FFFF);       fit = signed_fits(v, 26); end
            3'd3: begin imm = 26'((v & 64'h7FFFF) << 5);   fit = signed_fits(v, 19); end
            3'd4: begin imm = 26'((v & 64'h3F) << 10);     fit = (v < 64'd64); end
            3'd5: begin
                cnt = 0;
                idx = 0;
                hv  = '0;
                for (int k = 0; k < 4; k++) begin
                    h = (v >> (16 * k)) & 64'hFFFF;
                    if (h != 0) begin
                        cnt++;
                        idx = k;
                        hv  = h;
                    end
                end
                fit = (cnt <= 1);
                imm = fit ? 26'((64'(idx) << 21) | (hv << 5)) : '0;
            end
            default: begin imm = '0; fit = 1'b0; end
        endcase
    endfunction

    function automatic logic [63:0] extract(input logic [25:0] imm, input logic [2:0] c);
        logic [63:0] x;
        x = 64'(imm);
        case (c)
            3'd0: return (x >> 10) & 64'hFFF;
            3'd1: return sext(x >> 12, 9);
            3'd2: return sext(x, 26);
            3'd3: return sext(x >> 5, 19);
            3'd4: return (x >> 10) & 64'h3F;
            3'd5: return ((x >> 5) & 64'hFFFF) << (16 * ((x >> 21) & 64'h3));
            default: return '0;
        endcase
    endfunction

    // One full request: accept, latency, result, optional stall cycles, then the transfer.
    task automatic applyStimulus(input string tag, input logic [63:0] v, input logic [2:0] c,
                                 input int stall);
        logic [25:0] eimm;
        logic        efit;
        int          lat;
        bit          ok;
        model(v, c, eimm, efit);
        @(negedge CLK);
        BusImm  = v;
        Ctrl    = c;
        InValid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (InReady) begin ok = 1; break; end
            @(negedge CLK);
        end
        if (!ok) begin
            checkOutput({tag, " accept timeout"}, 0, 1);
            InValid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        InValid = 1'b0;
        BusImm  = {$urandom, $urandom};
        Ctrl    = 3'($urandom);
        lat = 1;
        ok  = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            lat++;
            #1;
            if (OutValid) begin ok = 1; break; end
        end
        if (!ok) begin
            checkOutput({tag, " result timeout"}, 0, 1);
            return;
        end
        checkOutput({tag, " latency"}, 64'(lat), (c == 3'd5) ? 64'd5 : 64'd2);
        checkOutput({tag, " imm"}, 64'(Imm25), 64'(eimm));
        checkOutput({tag, " fit"}, 64'(Fit), 64'(efit));
        if (efit && c <= 3'd5)
            checkOutput({tag, " roundtrip"}, extract(Imm25, c), v);
        for (int i = 0; i < stall; i++) begin
            @(negedge CLK);
            checkOutput({tag, " hold valid"}, 64'(OutValid), 64'd1);
            checkOutput({tag, " hold imm"}, 64'(Imm25), 64'(eimm));
            checkOutput({tag, " hold fit"}, 64'(Fit), 64'(efit));
            checkOutput({tag, " hold inready"}, 64'(InReady), 64'd0);
        end
        @(negedge CLK);
        OutReady = 1'b1;
        @(posedge CLK);
        #1;
        OutReady = 1'b0;
        checkOutput({tag, " drop valid"}, 64'(OutValid), 64'd0);
        checkOutput({tag, " inready after"}, 64'(InReady), 64'd1);
    endtask

    function automatic logic [63:0] fitting_value(input logic [2:0] c);
        logic [63:0] r;
        r = {$urandom, $urandom};
        case (c)
            3'd0: return r & 64'hFFF;
            3'd1: return sext(r, 9);
            3'd2: return sext(r, 26);
            3'd3: return sext(r, 19);
            3'd4: return r & 64'h3F;
            3'd5: return (r & 64'hFFFF) << (16 * $urandom_range(0, 3));
            default: return r;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] v;
        logic [2:0]  c;
        bit          seen;

        #1;
        checkOutput("reset inready", 64'(InReady), 64'd0);
        checkOutput("reset outvalid", 64'(OutValid), 64'd0);
        checkOutput("reset imm", 64'(Imm25), 64'd0);
        checkOutput("reset fit", 64'(Fit), 64'd0);
        repeat (3) @(negedge CLK);
        Reset_L = 1'b1;
        @(negedge CLK);
        checkOutput("post-reset inready", 64'(InReady), 64'd1);

        applyStimulus("I 0xABC", 64'hABC, 3'd0, 0);
        checkOutput("I 0xABC packed", 64'(Imm25), 64'h2AF000);
        applyStimulus("I 0x1000", 64'h1000, 3'd0, 0);
        applyStimulus("I 0xABC again", 64'hABC, 3'd0, 0);

        // Abort an IW scan partway through with an asynchronous reset.
        @(negedge CLK);
        BusImm  = 64'h0000_BEEF_0000_0000;
        Ctrl    = 3'd5;
        InValid = 1'b1;
        @(posedge CLK);
        #1;
        InValid = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        Reset_L = 1'b0;
        #1;
        checkOutput("midscan reset outvalid", 64'(OutValid), 64'd0);
        checkOutput("midscan reset imm", 64'(Imm25), 64'd0);
        checkOutput("midscan reset fit", 64'(Fit), 64'd0);
        checkOutput("midscan reset inready", 64'(InReady), 64'd0);
        @(negedge CLK);
        Reset_L = 1'b1;
        #1;
        checkOutput("release inready", 64'(InReady), 64'd1);
        seen = 0;
        repeat (6) begin
            @(negedge CLK);
            if (OutValid) seen = 1;
        end
        checkOutput("aborted op no output", 64'(seen), 64'd0);

        applyStimulus("D -256", 64'hFFFF_FFFF_FFFF_FF00, 3'd1, 0);
        checkOutput("D -256 field", 64'(Imm25[20:12]), 64'h100);
        applyStimulus("D 256", 64'h100, 3'd1, 0);
        applyStimulus("CB 0x40000", 64'h40000, 3'd3, 0);
        applyStimulus("CB -0x40000", 64'hFFFF_FFFF_FFFC_0000, 3'd3, 0);
        applyStimulus("B max", 64'h1FF_FFFF, 3'd2, 0);
        applyStimulus("B over", 64'h200_0000, 3'd2, 0);
        applyStimulus("R 63", 64'h3F, 3'd4, 0);
        applyStimulus("R 64", 64'h40, 3'd4, 0);
        applyStimulus("IW BEEF", 64'h0000_BEEF_0000_0000, 3'd5, 0);
        checkOutput("IW BEEF index", 64'(Imm25[22:21]), 64'd2);
        checkOutput("IW BEEF value", 64'(Imm25[20:5]), 64'hBEEF);
        applyStimulus("IW two", 64'h0001_0000_0000_0001, 3'd5, 0);
        applyStimulus("IW zero", 64'h0, 3'd5, 0);
        applyStimulus("IW top", 64'hFFFF_0000_0000_0000, 3'd5, 0);
        applyStimulus("backpressure", 64'hABC, 3'd0, 10);
        applyStimulus("illegal 111", 64'd5, 3'd7, 0);
        applyStimulus("illegal 110", 64'd5, 3'd6, 0);

        for (int n = 0; n < 60; n++) begin
            c = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0: v = {$urandom, $urandom};
                1: v = fitting_value(c);
                default: v = 64'($urandom_range(0, 70000));
            endcase
            applyStimulus($sformatf("rand%0d c%0d", n, c), v, c, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
